// File: rtl/keypad_scan_reader.sv
// 4x4 active-low matrix keypad scanner with frame-based press/release debounce.
// Optional auto-repeat of the held key is built when KEY_REPEAT_EN is defined.
module keypad_scan_reader #(
  parameter int SCAN_DIV      = 100000,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_FRAMES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);
  // state   | meaning
  // IDLE    | no key accepted, waiting for a single-key frame
  // CAND    | candidate key seen, counting identical single-key frames
  // PRESSED | key accepted and held
  // REL     | key-free frames seen, counting toward release
  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

  if (SCAN_DIV < 4) begin : g_chk_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_chk_db
    $error("DEBOUNCE_CNT must be 1..15");
  end
  if (REPEAT_FRAMES < 1) begin : g_chk_rep
    $error("REPEAT_FRAMES must be >= 1");
  end

  state_t        state;
  logic [3:0]    row_meta, row_sync;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_keys;
  logic [3:0]    acc_code;
  logic [3:0]    cand_code;
  logic [3:0]    db_cnt;

  logic [1:0] slot_keys, slot_row, frame_keys;
  logic [2:0] key_sum;
  logic [3:0] frame_code;
  logic       slot_end, frame_end, f_none, f_single;

  always_comb begin
    slot_keys = 2'd0;
    slot_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (slot_keys != 2'd2) slot_keys = slot_keys + 2'd1;
        slot_row = 2'(r);
      end
    end
    // key count saturates at 2: only NONE/SINGLE/MULTI matters
    key_sum    = {1'b0, acc_keys} + {1'b0, slot_keys};
    frame_keys = (key_sum >= 3'd2) ? 2'd2 : key_sum[1:0];
    frame_code = (slot_keys == 2'd1) ? {col_idx, slot_row} : acc_code;
    slot_end   = (slot_cnt == SLOT_LAST);
    frame_end  = slot_end && (col_idx == 2'd3);
    f_none     = (frame_keys == 2'd0);
    f_single   = (frame_keys == 2'd1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      col_out  <= 4'b1110;
      acc_keys <= 2'd0;
      acc_code <= 4'd0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        col_out  <= {col_out[2:0], col_out[3]};
        if (frame_end) begin
          acc_keys <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_keys <= frame_keys;
          acc_code <= frame_code;
        end
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RF = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rep_cnt;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cand_code <= 4'd0;
      db_cnt    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        multi_key <= (frame_keys == 2'd2);
        case (state)
          IDLE: begin
            if (f_single) begin
              if (DB == 4'd1) begin
                state     <= PRESSED;
                key_code  <= frame_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                db_cnt    <= 4'd0;
`ifdef KEY_REPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                state     <= CAND;
                cand_code <= frame_code;
                db_cnt    <= 4'd1;
              end
            end
          end
          CAND: begin
            if (f_single && frame_code == cand_code) begin
              if (db_cnt + 4'd1 == DB) begin
                state     <= PRESSED;
                key_code  <= cand_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                db_cnt    <= 4'd0;
`ifdef KEY_REPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                db_cnt <= db_cnt + 4'd1;
              end
            end else if (f_single) begin
              cand_code <= frame_code;
              db_cnt    <= 4'd1;
            end else begin
              state  <= IDLE;
              db_cnt <= 4'd0;
            end
          end
          PRESSED: begin
            if (f_none) begin
              if (DB == 4'd1) begin
                state    <= IDLE;
                key_held <= 1'b0;
                db_cnt   <= 4'd0;
              end else begin
                state  <= REL;
                db_cnt <= 4'd1;
              end
            end else begin
`ifdef KEY_REPEAT_EN
              if (rep_cnt + RW'(1) == RF) begin
                rep_cnt   <= '0;
                key_valid <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
`endif
            end
          end
          REL: begin
            if (f_none) begin
              if (db_cnt + 4'd1 == DB) begin
                state    <= IDLE;
                key_held <= 1'b0;
                db_cnt   <= 4'd0;
              end else begin
                db_cnt <= db_cnt + 4'd1;
              end
            end else begin
              // bounce on release: back to held without a new pulse
              state  <= PRESSED;
              db_cnt <= 4'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
